// File: rtl/bp_me_cache_pkt_to_cce_pkg.sv
// Shared types and opcode decode helpers for the cache-packet to BedRock bridge.
package bp_me_cache_pkt_to_cce_pkg;

    localparam int paddr_width_p  = 40;
    localparam int dword_width_p  = 64;
    localparam int lce_id_width_p = 4;

    // bsg_cache packet opcodes (encodings follow bsg_cache)
    typedef enum logic [5:0] {
        TAGST     = 6'h00,
        TAGFL     = 6'h01,
        TAGLV     = 6'h02,
        TAGLA     = 6'h03,
        AFL       = 6'h08,
        AFLINV    = 6'h09,
        AINV      = 6'h0A,
        ALOCK     = 6'h0B,
        AUNLOCK   = 6'h0C,
        LB        = 6'h10,
        LH        = 6'h11,
        LW        = 6'h12,
        LD        = 6'h13,
        LBU       = 6'h14,
        LHU       = 6'h15,
        LWU       = 6'h16,
        SB        = 6'h18,
        SH        = 6'h19,
        SW        = 6'h1A,
        SD        = 6'h1B,
        LM        = 6'h1C,
        SM        = 6'h1D,
        AMOSWAP_W = 6'h20,
        AMOADD_W  = 6'h21,
        AMOSWAP_D = 6'h30,
        AMOADD_D  = 6'h31
    } bsg_cache_opcode_e;

    typedef struct packed {
        bsg_cache_opcode_e              opcode;
        logic [paddr_width_p-1:0]       addr;
        logic [dword_width_p-1:0]       data;
        logic [dword_width_p/8-1:0]     mask;
    } bsg_cache_pkt_s;

    localparam int cache_pkt_width_lp = $bits(bsg_cache_pkt_s);

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1  = 3'd0,
        e_bedrock_msg_size_2  = 3'd1,
        e_bedrock_msg_size_4  = 3'd2,
        e_bedrock_msg_size_8  = 3'd3,
        e_bedrock_msg_size_16 = 3'd4,
        e_bedrock_msg_size_32 = 3'd5,
        e_bedrock_msg_size_64 = 3'd6
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0] lce_id;
        logic [2:0]                way_id;
        logic [2:0]                state;
        logic                      prefetch;
        logic                      uncached;
        logic                      speculative;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_payload_s   payload;
        bp_bedrock_msg_size_e      size;
        logic [paddr_width_p-1:0]  addr;
        logic [3:0]                subop;
        bp_bedrock_mem_type_e      msg_type;
    } bp_bedrock_mem_header_s;

    localparam int mem_header_width_lp = $bits(bp_bedrock_mem_header_s);

    typedef enum logic [1:0] {e_idle, e_send, e_wait, e_resp} bridge_state_e;

    function automatic logic is_load(bsg_cache_opcode_e op);
        return op inside {LB, LBU, LH, LHU, LW, LWU, LD};
    endfunction

    function automatic logic is_store(bsg_cache_opcode_e op);
        return op inside {SB, SH, SW, SD};
    endfunction

    function automatic logic is_signed(bsg_cache_opcode_e op);
        return op inside {LB, LH, LW};
    endfunction

    function automatic bp_bedrock_msg_size_e opcode_size(bsg_cache_opcode_e op);
        case (op)
            LB, LBU, SB: return e_bedrock_msg_size_1;
            LH, LHU, SH: return e_bedrock_msg_size_2;
            LW, LWU, SW: return e_bedrock_msg_size_4;
            default:     return e_bedrock_msg_size_8;
        endcase
    endfunction

    // Memory sees the store bytes wherever the lane lands, so fill every lane
    function automatic logic [dword_width_p-1:0] replicate_store(bp_bedrock_msg_size_e size,
                                                                 logic [dword_width_p-1:0] d);
        case (size)
            e_bedrock_msg_size_1: return {8{d[7:0]}};
            e_bedrock_msg_size_2: return {4{d[15:0]}};
            e_bedrock_msg_size_4: return {2{d[31:0]}};
            default:              return d;
        endcase
    endfunction

endpackage

// File: rtl/bp_me_cache_load_align.sv
// Sign/zero extension of an LSB-justified load response by access size.
module bp_me_cache_load_align
    import bp_me_cache_pkt_to_cce_pkg::*;
(
    input  logic [dword_width_p-1:0] data_i,
    input  bp_bedrock_msg_size_e     size_i,
    input  logic                     signed_i,
    output logic [dword_width_p-1:0] data_o
);

    // Extend the low bytes of the response to a full dword
    always_comb begin
        data_o = data_i;
        case (size_i)
            e_bedrock_msg_size_1: data_o = {{56{signed_i & data_i[7]}},  data_i[7:0]};
            e_bedrock_msg_size_2: data_o = {{48{signed_i & data_i[15]}}, data_i[15:0]};
            e_bedrock_msg_size_4: data_o = {{32{signed_i & data_i[31]}}, data_i[31:0]};
            default:              data_o = data_i;
        endcase
    end

endmodule

// File: rtl/bp_me_cache_pkt_to_cce.sv
// Bridge: single-dword bsg_cache packets in, one-beat uncached BedRock mem commands out.
module bp_me_cache_pkt_to_cce
    import bp_me_cache_pkt_to_cce_pkg::*;
#(
    parameter logic [lce_id_width_p-1:0] lce_id_p = '0
)
(
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [cache_pkt_width_lp-1:0]  cache_pkt_i,
    input  logic                           cache_pkt_v_i,
    output logic                           cache_pkt_ready_o,

    output logic [dword_width_p-1:0]       data_o,
    output logic                           v_o,
    input  logic                           yumi_i,
    output logic                           unsupported_o,

    output logic [mem_header_width_lp-1:0] mem_cmd_header_o,
    output logic [dword_width_p-1:0]       mem_cmd_data_o,
    output logic                           mem_cmd_v_o,
    input  logic                           mem_cmd_ready_i,
    output logic                           mem_cmd_lock_o,

    input  logic [mem_header_width_lp-1:0] mem_resp_header_i,
    input  logic [dword_width_p-1:0]       mem_resp_data_i,
    input  logic                           mem_resp_v_i,
    output logic                           mem_resp_yumi_o,
    input  logic                           mem_resp_lock_i
);

    bsg_cache_pkt_s           pkt;
    bridge_state_e            state_reg, state_next;
    bsg_cache_opcode_e        opcode_reg;
    logic [paddr_width_p-1:0] addr_reg;
    logic [dword_width_p-1:0] wdata_reg;
    logic [dword_width_p-1:0] data_reg;
    logic                     unsupported_reg;
    logic [dword_width_p-1:0] aligned_data;
    logic                     pkt_accept;
    logic                     pkt_supported;
    bp_bedrock_mem_header_s   cmd_header;

    // The response header is never checked and the lock is meaningless here
    logic unused_inputs;
    assign unused_inputs = ^{mem_resp_header_i, mem_resp_lock_i, pkt.mask};

    assign pkt           = bsg_cache_pkt_s'(cache_pkt_i);
    assign pkt_accept    = cache_pkt_v_i & cache_pkt_ready_o;
    assign pkt_supported = is_load(pkt.opcode) | is_store(pkt.opcode);

    bp_me_cache_load_align load_align (
        .data_i   (mem_resp_data_i),
        .size_i   (opcode_size(opcode_reg)),
        .signed_i (is_signed(opcode_reg)),
        .data_o   (aligned_data)
    );

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_reg <= e_idle;
        else            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            e_idle: if (pkt_accept)                    state_next = pkt_supported ? e_send : e_resp;
            e_send: if (mem_cmd_ready_i)               state_next = e_wait;
            e_wait: if (mem_resp_v_i)                  state_next = e_resp;
            e_resp: if (yumi_i)                        state_next = e_idle;
            default:                                   state_next = e_idle;
        endcase
    end

    // Outputs decoded from the state; header fields come from latched packet state
    always_comb begin
        cache_pkt_ready_o       = (state_reg == e_idle);
        mem_cmd_v_o             = (state_reg == e_send);
        v_o                     = (state_reg == e_resp);
        mem_resp_yumi_o         = mem_resp_v_i & ((state_reg == e_idle) | (state_reg == e_wait));
        mem_cmd_lock_o          = 1'b0;
        cmd_header              = '0;
        cmd_header.msg_type     = is_store(opcode_reg) ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        cmd_header.addr         = addr_reg;
        cmd_header.size         = opcode_size(opcode_reg);
        cmd_header.payload.lce_id = lce_id_p;
        mem_cmd_header_o        = cmd_header;
        mem_cmd_data_o          = is_store(opcode_reg)
                                  ? replicate_store(opcode_size(opcode_reg), wdata_reg)
                                  : '0;
        data_o                  = data_reg;
        unsupported_o           = unsupported_reg;
    end

    // Latch the packet on accept and capture formatted load data on response
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            opcode_reg      <= TAGST;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            data_reg        <= '0;
            unsupported_reg <= 1'b0;
        end else if (pkt_accept) begin
            opcode_reg      <= pkt.opcode;
            addr_reg        <= pkt.addr;
            wdata_reg       <= pkt.data;
            data_reg        <= '0;
            unsupported_reg <= ~pkt_supported;
        end else if ((state_reg == e_wait) && mem_resp_v_i) begin
            data_reg        <= is_load(opcode_reg) ? aligned_data : '0;
        end
    end

endmodule

// File: tb/tb_bp_me_cache_pkt_to_cce.sv
// Self-checking bench for bp_me_cache_pkt_to_cce: vector table plus corner-case sequences.
module tb_bp_me_cache_pkt_to_cce;
    import bp_me_cache_pkt_to_cce_pkg::*;

    localparam logic [lce_id_width_p-1:0] LCE_ID = 4'd5;

    logic                           clk = 1'b0;
    logic                           reset_n_i;
    logic [cache_pkt_width_lp-1:0]  cache_pkt_i;
    logic                           cache_pkt_v_i;
    logic                           cache_pkt_ready_o;
    logic [dword_width_p-1:0]       data_o;
    logic                           v_o;
    logic                           yumi_i;
    logic                           unsupported_o;
    logic [mem_header_width_lp-1:0] mem_cmd_header_o;
    logic [dword_width_p-1:0]       mem_cmd_data_o;
    logic                           mem_cmd_v_o;
    logic                           mem_cmd_ready_i;
    logic                           mem_cmd_lock_o;
    logic [mem_header_width_lp-1:0] mem_resp_header_i;
    logic [dword_width_p-1:0]       mem_resp_data_i;
    logic                           mem_resp_v_i;
    logic                           mem_resp_yumi_o;
    logic                           mem_resp_lock_i;

    bp_bedrock_mem_header_s hdr;
    assign hdr = bp_bedrock_mem_header_s'(mem_cmd_header_o);

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_me_cache_pkt_to_cce #(.lce_id_p(LCE_ID)) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n_i),
        .cache_pkt_i       (cache_pkt_i),
        .cache_pkt_v_i     (cache_pkt_v_i),
        .cache_pkt_ready_o (cache_pkt_ready_o),
        .data_o            (data_o),
        .v_o               (v_o),
        .yumi_i            (yumi_i),
        .unsupported_o     (unsupported_o),
        .mem_cmd_header_o  (mem_cmd_header_o),
        .mem_cmd_data_o    (mem_cmd_data_o),
        .mem_cmd_v_o       (mem_cmd_v_o),
        .mem_cmd_ready_i   (mem_cmd_ready_i),
        .mem_cmd_lock_o    (mem_cmd_lock_o),
        .mem_resp_header_i (mem_resp_header_i),
        .mem_resp_data_i   (mem_resp_data_i),
        .mem_resp_v_i      (mem_resp_v_i),
        .mem_resp_yumi_o   (mem_resp_yumi_o),
        .mem_resp_lock_i   (mem_resp_lock_i)
    );

    typedef struct {
        bsg_cache_opcode_e    opcode;
        logic [39:0]          addr;
        logic [63:0]          wdata;
        logic [63:0]          rdata;
        bp_bedrock_mem_type_e exp_type;
        bp_bedrock_msg_size_e exp_size;
        logic [63:0]          exp_cmd_data;
        logic [63:0]          exp_data;
        logic                 exp_unsup;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_pkt(input bsg_cache_opcode_e op, input logic [39:0] addr, input logic [63:0] wdata);
        bsg_cache_pkt_s p;
        @(negedge clk);
        p.opcode = op; p.addr = addr; p.data = wdata; p.mask = 8'hFF;
        cache_pkt_i   = p;
        cache_pkt_v_i = 1'b1;
        check("pkt_ready", cache_pkt_ready_o, 1'b1);
        @(negedge clk);
        cache_pkt_v_i = 1'b0;
    endtask

    // Waits (bounded) for mem_cmd_v_o, sampled on the falling edge
    task automatic wait_cmd();
        int n = 0;
        while (!mem_cmd_v_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_cmd_v_o) check("cmd_timeout", 1'b0, 1'b1);
    endtask

    task automatic accept_cmd();
        mem_cmd_ready_i = 1'b1;
        @(negedge clk);
        mem_cmd_ready_i = 1'b0;
    endtask

    task automatic give_resp(input logic [63:0] d);
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = d;
        #1 check("resp_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk);
        mem_resp_v_i = 1'b0;
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
        check("idle_v_o", v_o, 1'b0);
        check("idle_ready", cache_pkt_ready_o, 1'b1);
    endtask

    task automatic do_txn(input vec_t v);
        send_pkt(v.opcode, v.addr, v.wdata);
        if (!v.exp_unsup) begin
            wait_cmd();
            check("cmd_type", hdr.msg_type, v.exp_type);
            check("cmd_size", hdr.size, v.exp_size);
            check("cmd_addr", hdr.addr, v.addr);
            check("cmd_lce", hdr.payload.lce_id, LCE_ID);
            check("cmd_data", mem_cmd_data_o, v.exp_cmd_data);
            accept_cmd();
            give_resp(v.rdata);
        end else begin
            check("unsup_no_cmd", mem_cmd_v_o, 1'b0);
        end
        check("v_o", v_o, 1'b1);
        check("data_o", data_o, v.exp_data);
        check("unsupported_o", unsupported_o, v.exp_unsup);
        $display("txn op=%s addr=%h data_o=%h unsup=%b", v.opcode.name(), v.addr, data_o, unsupported_o);
        consume();
    endtask

    initial begin
        vecs[0]  = '{LW,  40'h80000004, 64'h0, 64'h0000_0000_8000_0001, e_bedrock_mem_uc_rd, e_bedrock_msg_size_4, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b0};
        vecs[1]  = '{SB,  40'h80000003, 64'hA5, 64'hDEAD_BEEF_DEAD_BEEF, e_bedrock_mem_uc_wr, e_bedrock_msg_size_1, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 1'b0};
        vecs[2]  = '{LBU, 40'h80000010, 64'h0, 64'h0000_0000_0000_00FF, e_bedrock_mem_uc_rd, e_bedrock_msg_size_1, 64'h0, 64'h0000_0000_0000_00FF, 1'b0};
        vecs[3]  = '{LB,  40'h80000011, 64'h0, 64'h1234_5678_9ABC_DE80, e_bedrock_mem_uc_rd, e_bedrock_msg_size_1, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        vecs[4]  = '{LH,  40'h80000012, 64'h0, 64'h0000_0000_0000_8001, e_bedrock_mem_uc_rd, e_bedrock_msg_size_2, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
        vecs[5]  = '{LHU, 40'h80000016, 64'h0, 64'hFFFF_FFFF_FFFF_7FFF, e_bedrock_mem_uc_rd, e_bedrock_msg_size_2, 64'h0, 64'h0000_0000_0000_7FFF, 1'b0};
        vecs[6]  = '{LWU, 40'h80000020, 64'h0, 64'hAAAA_AAAA_8765_4321, e_bedrock_mem_uc_rd, e_bedrock_msg_size_4, 64'h0, 64'h0000_0000_8765_4321, 1'b0};
        vecs[7]  = '{LD,  40'h80000028, 64'h0, 64'h0123_4567_89AB_CDEF, e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[8]  = '{SH,  40'h80000032, 64'h1111_2222_3333_BEEF, 64'h0, e_bedrock_mem_uc_wr, e_bedrock_msg_size_2, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0, 1'b0};
        vecs[9]  = '{SW,  40'h80000034, 64'h1111_2222_CAFE_F00D, 64'h0, e_bedrock_mem_uc_wr, e_bedrock_msg_size_4, 64'hCAFE_F00D_CAFE_F00D, 64'h0, 1'b0};
        vecs[10] = '{SD,  40'h80000038, 64'h0123_4567_89AB_CDEF, 64'h0, e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[11] = '{AMOSWAP_W, 40'h80000040, 64'h5, 64'h0, e_bedrock_mem_uc_rd, e_bedrock_msg_size_4, 64'h0, 64'h0, 1'b1};

        cache_pkt_i = '0; cache_pkt_v_i = 0; yumi_i = 0; mem_cmd_ready_i = 0;
        mem_resp_header_i = '0; mem_resp_data_i = '0; mem_resp_lock_i = 0;
        mem_resp_v_i = 1'b1;
        reset_n_i = 1'b0;

        // Reset state, with a stray response present
        repeat (2) @(negedge clk);
        check("rst_ready", cache_pkt_ready_o, 1'b1);
        check("rst_v_o", v_o, 1'b0);
        check("rst_cmd_v", mem_cmd_v_o, 1'b0);
        check("rst_lock", mem_cmd_lock_o, 1'b0);
        check("rst_data_o", data_o, 64'h0);
        check("rst_unsup", unsupported_o, 1'b0);
        check("rst_drain", mem_resp_yumi_o, 1'b1);
        mem_resp_v_i = 1'b0;
        reset_n_i = 1'b1;

        for (int i = 0; i < 12; i++) do_txn(vecs[i]);

        // Best-case load latency: ready memory with response always present
        begin
            int n;
            bsg_cache_pkt_s p;
            mem_cmd_ready_i = 1'b1;
            mem_resp_v_i    = 1'b1;
            mem_resp_data_i = 64'h0BAD_F00D_1234_5678;
            p.opcode = LD; p.addr = 40'h80000100; p.data = '0; p.mask = 8'hFF;
            @(negedge clk);
            cache_pkt_i = p; cache_pkt_v_i = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                cache_pkt_v_i = 1'b0;
                n++;
            end while (!v_o && n < 10);
            check("load_latency", n, 3);
            check("latency_data", data_o, 64'h0BAD_F00D_1234_5678);
            mem_cmd_ready_i = 1'b0;
            mem_resp_v_i    = 1'b0;
            consume();
        end

        // Unsupported latency: v_o one cycle after accept
        send_pkt(TAGFL, 40'h80000000, 64'h0);
        check("unsup_latency_v", v_o, 1'b1);
        check("unsup_flag", unsupported_o, 1'b1);
        check("unsup_data", data_o, 64'h0);
        check("unsup_no_cmd2", mem_cmd_v_o, 1'b0);
        consume();

        // Command backpressure: header and data held while ready is low
        send_pkt(SW, 40'h80000104, 64'h0000_0000_1234_5678);
        wait_cmd();
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_v", mem_cmd_v_o, 1'b1);
            check("bp_addr", hdr.addr, 40'h80000104);
            check("bp_size", hdr.size, e_bedrock_msg_size_4);
            check("bp_type", hdr.msg_type, e_bedrock_mem_uc_wr);
            check("bp_data", mem_cmd_data_o, 64'h1234_5678_1234_5678);
            @(negedge clk);
        end
        accept_cmd();
        give_resp(64'h0);
        check("bp_store_data", data_o, 64'h0);
        consume();

        // Result backpressure: v_o/data_o held while yumi is low
        send_pkt(LW, 40'h80000108, 64'h0);
        wait_cmd();
        accept_cmd();
        give_resp(64'h0000_0000_7FFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            check("hold_v_o", v_o, 1'b1);
            check("hold_data", data_o, 64'h0000_0000_7FFF_FFFE);
            check("hold_ready", cache_pkt_ready_o, 1'b0);
            @(negedge clk);
        end
        consume();

        // Reset while waiting for a response, then a stray response arrives
        send_pkt(LD, 40'h80000200, 64'h0);
        wait_cmd();
        accept_cmd();
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_ready", cache_pkt_ready_o, 1'b1);
        check("mid_rst_cmd_v", mem_cmd_v_o, 1'b0);
        @(negedge clk);
        reset_n_i = 1'b1;
        give_resp(64'hFFFF_0000_FFFF_0000);
        check("stray_v_o", v_o, 1'b0);
        check("stray_ready", cache_pkt_ready_o, 1'b1);
        $display("txn reset-abandoned LD, stray response drained");
        do_txn('{LD, 40'h80000208, 64'h0, 64'hFEDC_BA98_7654_3210, e_bedrock_mem_uc_rd,
                 e_bedrock_msg_size_8, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bp_me_cache_pkt_to_cce.md
# bp_me_cache_pkt_to_cce

Bridge from a bsg_cache packet client to a BedRock CCE memory interface. Accepts single-dword bsg_cache load/store packets and emits one-beat uncached BedRock mem commands (e_bedrock_mem_uc_rd / e_bedrock_mem_uc_wr). Collects the matching mem response and returns load data in bsg_cache format. It sits where a cache-packet master must reach BedRock memory or CSR space: the inverse direction of the CCE-to-cache adapter. One transaction is outstanding at a time.

## Interface

Parameters:
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, dword_width_p (64), lce_id_width_p, cce_block_width_p.
- lce_id_p, 0: value driven into the payload lce_id of every command.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- cache_pkt_i  in  bsg_cache_pkt_width(paddr_width_p,dword_width_p)  incoming packet.
- cache_pkt_v_i  in  1  packet valid.
- cache_pkt_ready_o  out  1  packet accepted when v & ready.
- data_o  out  dword_width_p  load result; 0 for stores and unsupported ops.
- v_o  out  1  result valid.
- yumi_i  in  1  result consumed.
- unsupported_o  out  1  qualifies v_o; the packet opcode was not serviced.
- mem_cmd_header_o  out  bp_bedrock_cce_mem_msg_header_width  command header.
- mem_cmd_data_o  out  dword_width_p  command data beat.
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_ready_i  in  1  command accepted when v & ready.
- mem_cmd_lock_o  out  1  constant 0.
- mem_resp_header_i  in  header width  response header.
- mem_resp_data_i  in  dword_width_p  response data; requested bytes are in the LSBs.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed.
- mem_resp_lock_i  in  1  ignored.

## Operation

The FSM has four states: e_idle, e_send, e_wait, e_resp.

- **e_idle**
  - cache_pkt_ready_o=1.
  - On accept, latch opcode, addr and data.
  - Supported opcodes go to e_send: LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD.
  - Any other opcode (TAGST, TAGFL, TAGLA, TAGLV, AFL, AFLINV, AINV, LM, SM, AMO*) goes directly to e_resp with unsupported_o=1 and data_o=0. No memory traffic is issued.
  - mem_resp_yumi_o=mem_resp_v_i, so stray responses are drained.
- **e_send**
  - mem_cmd_v_o=1.
  - Header fields:
    - msg_type = uc_rd for loads, uc_wr for stores.
    - addr = latched addr, unaligned bits preserved.
    - size: B→size_1, H→size_2, W→size_4, D→size_8.
    - payload.lce_id = lce_id_p; all other header fields are 0.
  - Store data is replicated across the dword. SB: 8× byte; SH: 4× half; SW: 2× word; SD: as-is. For loads, mem_cmd_data_o=0.
  - On mem_cmd_v_o & mem_cmd_ready_i, go to e_wait.
- **e_wait**
  - mem_resp_yumi_o=mem_resp_v_i.
  - On a response, register data_o and go to e_resp.
  - Load formatting:
    - LB, LH, LW: sign-extend bits [7:0], [15:0], [31:0].
    - LBU, LHU, LWU: zero-extend.
    - LD: full dword.
  - Stores produce data_o=0.
- **e_resp**
  - v_o=1; data_o and unsupported_o are held stable.
  - On yumi_i, go to e_idle.
- The response header is not checked against the command.

## Timing

- **Reset:** asynchronous assert forces e_idle immediately. Registered outputs clear: data_o=0, unsupported_o=0, and latched fields cleared. Combinational outputs follow e_idle:
  - cache_pkt_ready_o=1, v_o=0, mem_cmd_v_o=0, mem_cmd_lock_o=0.
  - mem_resp_yumi_o=mem_resp_v_i, so stray responses drain from reset onward.
- **Reset mid-transaction:** the transaction is abandoned. Any late response is drained in e_idle.
- **Latency:** packet accepted at cycle 0; mem_cmd_v_o at cycle 1. A response accepted at cycle N gives v_o at N+1. Best-case load, with mem ready and a same-cycle response: v_o at cycle 3. Unsupported op: v_o at cycle 1.
- **Handshakes:**
  - mem_cmd_* and the header are stable while v & !ready.
  - mem_resp_yumi_o depends only on mem_resp_v_i and state.
  - yumi_i is legal only while v_o=1.
- **Back-to-back:** a new packet can be accepted the cycle after yumi_i. Throughput is at most one packet per 4 cycles.
- **Sequencing:** the next packet cannot be accepted in the same cycle as yumi_i.

## Structure

- Opcode decode helpers belong in bp_me_pkg: is_load, is_store, is_signed, and opcode→bp_bedrock_msg_size_e.
- Header types come from the declare_bp_bedrock_mem_if macros; the packet type comes from declare_bsg_cache_pkt_s.
- Sub-module bp_me_cache_load_align: combinational sign/zero extension of response data by size and signedness. It is reusable by other bridges.
- Expected size: 150–250 lines.

## Test plan

- **LW, negative:** LW addr=0x8000_0004, response data=0x0000_0000_8000_0001 → header uc_rd, size_4, addr 0x8000_0004; data_o=0xFFFF_FFFF_8000_0001.
- **SB:** SB addr=0x8000_0003, data=0xA5 → mem_cmd_data_o=0xA5A5_A5A5_A5A5_A5A5, msg_type uc_wr, size_1; data_o=0 after the response.
- **Backpressure:** hold mem_cmd_ready_i=0 for 5 cycles → header and data stable throughout. Hold yumi_i=0 for 4 cycles → v_o and data_o stable and cache_pkt_ready_o=0.
- **Unsupported op:** TAGFL packet → no mem_cmd_v_o; v_o=1 at cycle 1 with unsupported_o=1 and data_o=0.
- **Reset mid-transaction:** assert reset_n_i=0 in e_wait, release, then inject a stray response → it is drained (yumi=1), v_o stays 0. A following LD returns correct data.
- **Unsigned load:** LBU response 0xFF → data_o=0x0000_0000_0000_00FF.
